// File: rtl/axi_dma_wr_engine.sv
// AXI4 write-channel DMA master.
// Pulls num_trans 32-bit words one at a time from a producer and writes them
// to memory from mem_start_addr in INCR bursts of at most 16 beats. Only one
// burst is outstanding, and only one beat is in flight.
module axi_dma_wr_engine #(
    parameter int BITS_TRANS     = 18,
    parameter int OUT_BITS_TRANS = 13,
    parameter int AXI_WIDTH_USER = 1,
    parameter int AXI_WIDTH_ID   = 4,
    parameter int AXI_WIDTH_AD   = 32,
    parameter int AXI_WIDTH_DA   = 32,
    parameter int AXI_WIDTH_DS   = AXI_WIDTH_DA / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    // AW channel
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
    output logic [7:0]                M_AWLEN,
    output logic [AXI_WIDTH_ID-1:0]   M_AWID,
    output logic [2:0]                M_AWSIZE,
    output logic [1:0]                M_AWBURST,
    output logic [1:0]                M_AWLOCK,
    output logic [3:0]                M_AWCACHE,
    output logic [2:0]                M_AWPROT,
    output logic [3:0]                M_AWQOS,
    output logic [3:0]                M_AWREGION,
    output logic [AXI_WIDTH_USER-1:0] M_AWUSER,
    // W channel
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
    output logic [AXI_WIDTH_DS-1:0]   M_WSTRB,
    output logic                      M_WLAST,
    output logic [AXI_WIDTH_ID-1:0]   M_WID,
    output logic [AXI_WIDTH_USER-1:0] M_WUSER,
    // B channel
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    input  logic [1:0]                M_BRESP,
    input  logic [AXI_WIDTH_ID-1:0]   M_BID,
    input  logic [AXI_WIDTH_USER-1:0] M_BUSER,
    // control and producer side
    input  logic                      ap_start,
    output logic                      ap_done,
    input  logic [BITS_TRANS-1:0]     num_trans,
    input  logic [AXI_WIDTH_AD-1:0]   mem_start_addr,
    input  logic [AXI_WIDTH_DA-1:0]   indata,
    output logic                      indata_req_o,
    input  logic                      buff_valid,
    output logic                      fail_check
);

    localparam int BURST_MAX = 16;
    localparam int SIZE_LOG2 = $clog2(AXI_WIDTH_DS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REQ  = 3'd2,
        S_CAP  = 3'd3,
        S_DATA = 3'd4,
        S_RESP = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                    r_state;
    logic [BITS_TRANS-1:0]     r_remain;
    logic [AXI_WIDTH_AD-1:0]   r_addr;
    logic [OUT_BITS_TRANS-1:0] r_bursts;
    logic [4:0]                r_blen;
    logic [4:0]                r_beat;
    logic                      r_awvalid;
    logic [AXI_WIDTH_AD-1:0]   r_awaddr;
    logic [7:0]                r_awlen;
    logic                      r_wvalid;
    logic [AXI_WIDTH_DA-1:0]   r_wdata;
    logic                      r_wlast;
    logic                      r_bready;
    logic                      r_done;
    logic                      r_fail;

    logic [4:0]                w_start_blen;
    logic [BITS_TRANS:0]       w_nburst_full;
    logic [OUT_BITS_TRANS-1:0] w_start_bursts;
    logic [BITS_TRANS-1:0]     w_remain_nxt;
    logic [AXI_WIDTH_AD-1:0]   w_addr_nxt;
    logic [4:0]                w_next_blen;
    logic                      w_last_beat;
    logic                      w_unused;

    // Burst sizing for the first burst and for the burst after each response.
    assign w_start_blen   = (num_trans >= BITS_TRANS'(BURST_MAX)) ? 5'd16 : num_trans[4:0];
    assign w_nburst_full  = {1'b0, num_trans} + (BITS_TRANS+1)'(BURST_MAX - 1);
    assign w_start_bursts = w_nburst_full[OUT_BITS_TRANS+3:4];
    assign w_remain_nxt   = r_remain - BITS_TRANS'(r_blen);
    assign w_addr_nxt     = r_addr + (AXI_WIDTH_AD'(r_blen) << SIZE_LOG2);
    assign w_next_blen    = (w_remain_nxt >= BITS_TRANS'(BURST_MAX)) ? 5'd16 : w_remain_nxt[4:0];
    assign w_last_beat    = (r_beat == (r_blen - 5'd1));

    // B-channel ID/USER are don't-care, as are the dropped bits of the burst count.
    assign w_unused = ^{M_BID, M_BUSER, w_nburst_full[3:0],
                        w_nburst_full[BITS_TRANS:OUT_BITS_TRANS+4]};

    // The request is gated by buff_valid in the same cycle so the producer is
    // never asked for a word it does not have; the word arrives in CAP.
    assign indata_req_o = (r_state == S_REQ) & buff_valid;

    assign M_AWVALID  = r_awvalid;
    assign M_AWADDR   = r_awaddr;
    assign M_AWLEN    = r_awlen;
    assign M_AWID     = {AXI_WIDTH_ID{1'b0}};
    assign M_AWSIZE   = 3'(SIZE_LOG2);
    assign M_AWBURST  = 2'b01;
    assign M_AWLOCK   = 2'b00;
    assign M_AWCACHE  = 4'b0000;
    assign M_AWPROT   = 3'b000;
    assign M_AWQOS    = 4'b0000;
    assign M_AWREGION = 4'b0000;
    assign M_AWUSER   = {AXI_WIDTH_USER{1'b0}};
    assign M_WVALID   = r_wvalid;
    assign M_WDATA    = r_wdata;
    assign M_WSTRB    = {AXI_WIDTH_DS{1'b1}};
    assign M_WLAST    = r_wlast;
    assign M_WID      = {AXI_WIDTH_ID{1'b0}};
    assign M_WUSER    = {AXI_WIDTH_USER{1'b0}};
    assign M_BREADY   = r_bready;
    assign ap_done    = r_done;
    assign fail_check = r_fail;

    // Transfer sequencer: outputs are registered on entry to the state that drives them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_remain  <= {BITS_TRANS{1'b0}};
            r_addr    <= {AXI_WIDTH_AD{1'b0}};
            r_bursts  <= {OUT_BITS_TRANS{1'b0}};
            r_blen    <= 5'd0;
            r_beat    <= 5'd0;
            r_awvalid <= 1'b0;
            r_awaddr  <= {AXI_WIDTH_AD{1'b0}};
            r_awlen   <= 8'd0;
            r_wvalid  <= 1'b0;
            r_wdata   <= {AXI_WIDTH_DA{1'b0}};
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_fail   <= 1'b0;
                        r_remain <= num_trans;
                        r_addr   <= mem_start_addr;
                        r_bursts <= w_start_bursts;
                        if (num_trans == BITS_TRANS'(0)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_awaddr  <= mem_start_addr;
                            r_awlen   <= 8'(w_start_blen - 5'd1);
                            r_blen    <= w_start_blen;
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (M_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= 5'd0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (buff_valid) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_wdata  <= indata;
                    r_wvalid <= 1'b1;
                    r_wlast  <= w_last_beat;
                    r_state  <= S_DATA;
                end
                S_DATA: begin
                    if (M_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        if (w_last_beat) begin
                            r_bready <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_beat  <= r_beat + 5'd1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_RESP: begin
                    if (M_BVALID) begin
                        r_bready <= 1'b0;
                        if (M_BRESP != 2'b00) begin
                            r_fail <= 1'b1;
                        end
                        r_remain <= w_remain_nxt;
                        r_addr   <= w_addr_nxt;
                        r_bursts <= r_bursts - OUT_BITS_TRANS'(1);
                        if (r_bursts == OUT_BITS_TRANS'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_awaddr  <= w_addr_nxt;
                            r_awlen   <= 8'(w_next_blen - 5'd1);
                            r_blen    <= w_next_blen;
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_wr_engine.sv
// Self-checking bench for axi_dma_wr_engine: randomized AXI slave and producer,
// transaction-level reference model, per-cycle compare process.
module tb_axi_dma_wr_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        M_AWVALID, M_AWREADY;
    logic [31:0] M_AWADDR;
    logic [7:0]  M_AWLEN;
    logic [3:0]  M_AWID, M_WID;
    logic [2:0]  M_AWSIZE, M_AWPROT;
    logic [1:0]  M_AWBURST, M_AWLOCK, M_BRESP;
    logic [3:0]  M_AWCACHE, M_AWQOS, M_AWREGION, M_WSTRB, M_BID;
    logic [0:0]  M_AWUSER, M_WUSER, M_BUSER;
    logic        M_WVALID, M_WREADY, M_WLAST, M_BVALID, M_BREADY;
    logic [31:0] M_WDATA;
    logic        ap_start, ap_done, indata_req_o, buff_valid, fail_check;
    logic [17:0] num_trans;
    logic [31:0] mem_start_addr, indata;

    axi_dma_wr_engine dut (
        .clk(clk), .rstn(rstn),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
        .M_AWID(M_AWID), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK),
        .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWREGION(M_AWREGION),
        .M_AWUSER(M_AWUSER), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA),
        .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WID(M_WID), .M_WUSER(M_WUSER),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP), .M_BID(M_BID),
        .M_BUSER(M_BUSER), .ap_start(ap_start), .ap_done(ap_done), .num_trans(num_trans),
        .mem_start_addr(mem_start_addr), .indata(indata), .indata_req_o(indata_req_o),
        .buff_valid(buff_valid), .fail_check(fail_check)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [7:0] l; } aw_t;

    int n_vec = 0, n_err = 0;
    // transfer description and expectations
    logic [31:0] data_q[$];
    aw_t         exp_aw[$], aw_log[$];
    int          exp_n;
    logic [31:0] exp_addr;
    logic [31:0] mem [int unsigned];
    // progress counters
    int aw_idx, w_idx, b_cnt, req_cnt, prod_idx, done_cnt, beat_in_burst, cyc, start_cyc, done_cyc;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;
    bit busy, b_pending, req_fire, outstanding, exp_done_nxt, exp_aw_nxt, exp_fail;
    bit aw_stalled, w_stalled;
    logic [39:0] aw_prev;
    logic [32:0] w_prev;
    int b_delay;
    // slave / producer configuration
    int cfg_rand, cfg_aw_stall, cfg_w_stall, cfg_w_beat, cfg_pv_stall, cfg_pv_beat, cfg_err_burst, cfg_bdly;
    int aw_wait, w_wait, pv_wait;

    localparam logic [35:0] CONST_EXP = {4'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0,
                                         4'h0, 4'h0, 1'b0, 1'b0, 4'hf};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rnd(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, {M_AWVALID, M_WVALID, M_BREADY, M_WLAST, ap_done, indata_req_o, fail_check}, 7'd0);
        check({tag, "_awaddr"}, M_AWADDR, 32'd0);
        check({tag, "_awlen"}, M_AWLEN, 8'd0);
        check({tag, "_wdata"}, M_WDATA, 32'd0);
        check({tag, "_const"}, {M_AWID, M_WID, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWCACHE, M_AWPROT,
                                M_AWQOS, M_AWREGION, M_AWUSER, M_WUSER, M_WSTRB}, CONST_EXP);
    endtask

    // Compare process body: runs once per cycle, inputs final for the coming edge.
    task automatic mon();
        bit done_cur, aw_cur;
        cyc++;
        if (!rstn) begin
            check_reset_vals("rst");
            busy = 0; b_pending = 0; outstanding = 0; exp_done_nxt = 0; exp_aw_nxt = 0;
            exp_fail = 0; aw_stalled = 0; w_stalled = 0; req_fire = 0;
        end else begin
            done_cur = exp_done_nxt; exp_done_nxt = 0;
            aw_cur   = exp_aw_nxt;   exp_aw_nxt   = 0;
            check("const", {M_AWID, M_WID, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWCACHE, M_AWPROT,
                            M_AWQOS, M_AWREGION, M_AWUSER, M_WUSER, M_WSTRB}, CONST_EXP);
            check("ap_done", ap_done, done_cur);
            if (ap_done) begin done_cnt++; done_cyc = cyc; end
            if (aw_cur) check("awvalid_latency", M_AWVALID, 1'b1);
            check("fail_check", fail_check, exp_fail);
            if (aw_stalled) check("aw_hold", {M_AWVALID, M_AWADDR, M_AWLEN}, {1'b1, aw_prev});
            if (w_stalled)  check("w_hold", {M_WVALID, M_WDATA, M_WLAST}, {1'b1, w_prev});
            aw_stalled = M_AWVALID && !M_AWREADY;
            aw_prev    = {M_AWADDR, M_AWLEN};
            w_stalled  = M_WVALID && !M_WREADY;
            w_prev     = {M_WDATA, M_WLAST};
            if (indata_req_o) begin
                check("req_gated", buff_valid, 1'b1);
                check("req_busy", busy, 1'b1);
                req_cnt++;
                check("req_bound", (req_cnt <= exp_n), 1'b1);
                req_fire = 1;
            end
            if (M_AWVALID && M_AWREADY) begin
                check("aw_after_b", outstanding, 1'b0);
                if (aw_idx < exp_aw.size()) check("aw", {M_AWADDR, M_AWLEN}, exp_aw[aw_idx]);
                else check("aw_extra", aw_idx, exp_aw.size());
                aw_log.push_back({M_AWADDR, M_AWLEN});
                aw_idx++; cur_addr = M_AWADDR; cur_len = M_AWLEN;
                beat_in_burst = 0; outstanding = 1; aw_wait = 0;
            end
            if (M_WVALID && M_WREADY) begin
                check("w_in_burst", outstanding, 1'b1);
                if (w_idx < data_q.size()) check("wdata", M_WDATA, data_q[w_idx]);
                else check("w_extra", w_idx, data_q.size());
                check("wlast", M_WLAST, (beat_in_burst == int'(cur_len)));
                mem[cur_addr + 32'(4 * beat_in_burst)] = M_WDATA;
                beat_in_burst++; w_idx++;
                if (M_WLAST) begin b_pending = 1; b_delay = $urandom_range(0, cfg_bdly); end
            end
            if (M_BVALID && M_BREADY) begin
                if (M_BRESP != 2'b00) exp_fail = 1;
                b_pending = 0; outstanding = 0; b_cnt++;
                if (b_cnt == exp_aw.size()) exp_done_nxt = 1;
            end
            if (ap_start && !busy) begin
                busy = 1; start_cyc = cyc; exp_fail = 0;
                if (exp_n == 0) exp_done_nxt = 1; else exp_aw_nxt = 1;
            end
            if (done_cur) busy = 0;
        end
    endtask

    // Slave + producer driver on the falling edge, then the compare step.
    initial begin : slave_and_monitor
        forever begin
            @(negedge clk);
            if (!rstn) begin
                M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0; M_BID = 0; M_BUSER = 0;
                buff_valid = 0; indata = 0;
            end else begin
                if (M_AWVALID && aw_wait < cfg_aw_stall) begin M_AWREADY = 0; aw_wait++; end
                else M_AWREADY = cfg_rand ? rnd(70) : 1'b1;
                if (M_WVALID && w_idx == cfg_w_beat && w_wait < cfg_w_stall) begin M_WREADY = 0; w_wait++; end
                else M_WREADY = cfg_rand ? rnd(70) : 1'b1;
                M_BID = 4'($urandom); M_BUSER = 1'($urandom);
                if (b_pending && b_delay == 0) begin
                    M_BVALID = 1;
                    M_BRESP  = (b_cnt == cfg_err_burst) ? 2'b10 : 2'b00;
                end else begin
                    if (b_pending) b_delay--;
                    M_BVALID = 0; M_BRESP = 2'($urandom);
                end
                if (req_fire && prod_idx < data_q.size()) begin indata = data_q[prod_idx]; prod_idx++; end
                else indata = $urandom;
                req_fire = 0;
                if (w_idx == cfg_pv_beat && pv_wait < cfg_pv_stall) begin buff_valid = 0; pv_wait++; end
                else buff_valid = cfg_rand ? rnd(75) : 1'b1;
            end
            #2;
            mon();
        end
    end

    task automatic set_cfg(input int r, input int aws, input int ws, input int wb,
                           input int ps, input int pb, input int eb, input int bd);
        cfg_rand = r; cfg_aw_stall = aws; cfg_w_stall = ws; cfg_w_beat = wb;
        cfg_pv_stall = ps; cfg_pv_beat = pb; cfg_err_burst = eb; cfg_bdly = bd;
    endtask

    // Build the expected transfer from the burst-splitting rule.
    task automatic setup(input int n, input logic [31:0] addr, input bit seq);
        data_q.delete(); exp_aw.delete(); aw_log.delete(); mem.delete();
        for (int i = 0; i < n; i++) data_q.push_back(seq ? 32'(i) : $urandom);
        for (int k = 0; k * 16 < n; k++) begin
            int len = (n - 16 * k > 16) ? 16 : n - 16 * k;
            exp_aw.push_back({addr + 32'(64 * k), 8'(len - 1)});
        end
        exp_n = n; exp_addr = addr;
        aw_idx = 0; w_idx = 0; b_cnt = 0; req_cnt = 0; prod_idx = 0; done_cnt = 0;
        aw_wait = 0; w_wait = 0; pv_wait = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        num_trans = 18'(exp_n); mem_start_addr = exp_addr; ap_start = 1;
        @(negedge clk);
        ap_start = 0; num_trans = 18'($urandom); mem_start_addr = $urandom;
    endtask

    task automatic wait_done(input bit spurious);
        int bound = 40 * exp_n + 300;
        int i;
        for (i = 0; i < bound && done_cnt == 0; i++) begin
            @(negedge clk);
            if (spurious && i == 8) begin ap_start = 1; num_trans = 18'd5; end
            else ap_start = 0;
        end
        ap_start = 0;
        check("done_within_bound", (done_cnt > 0), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic end_checks();
        check("done_pulses", done_cnt, 1);
        check("req_total", req_cnt, exp_n);
        check("aw_total", aw_idx, exp_aw.size());
        check("w_total", w_idx, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            int unsigned key = exp_addr + 32'(4 * i);
            check("mem_written", mem.exists(key), 1'b1);
            if (mem.exists(key)) check("mem_data", mem[key], data_q[i]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rstn = 0; ap_start = 0; num_trans = 0; mem_start_addr = 0;
        set_cfg(0, 0, 0, -1, 0, -1, -1, 0);
        setup(0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);

        // single burst, ideal slave and producer
        set_cfg(0, 0, 0, -1, 0, -1, -1, 0);
        setup(8, 32'h0, 1'b1);
        do_start(); wait_done(1'b0); end_checks();
        check("t1_aw_count", aw_log.size(), 1);
        if (aw_log.size() == 1) check("t1_aw", aw_log[0], {32'h0, 8'd7});
        check("t1_mem7", mem[28], 32'd7);
        check("t1_latency", done_cyc - start_cyc, 27);
        check("t1_fail", fail_check, 1'b0);

        // multi-burst with random handshakes
        set_cfg(1, 0, 0, -1, 0, -1, -1, 3);
        setup(40, 32'h100, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t2_aw_count", aw_log.size(), 3);
        if (aw_log.size() == 3) begin
            check("t2_aw0", aw_log[0], {32'h100, 8'd15});
            check("t2_aw1", aw_log[1], {32'h140, 8'd15});
            check("t2_aw2", aw_log[2], {32'h180, 8'd7});
        end

        // slave backpressure: AWREADY low 4 cycles, WREADY low 5 cycles on beat 3
        set_cfg(0, 4, 5, 3, 0, -1, -1, 1);
        setup(20, 32'h40, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t3_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2) check("t3_aw1", aw_log[1], {32'h80, 8'd3});

        // producer stall of 10 cycles before beat 5
        set_cfg(0, 0, 0, -1, 10, 5, -1, 0);
        setup(16, 32'h200, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t4_latency", done_cyc - start_cyc, 61);

        // error response on the first of two bursts, then cleared by next start
        set_cfg(1, 0, 0, -1, 0, -1, 0, 2);
        setup(32, 32'h1000, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t5_fail_sticky", fail_check, 1'b1);
        set_cfg(1, 0, 0, -1, 0, -1, -1, 2);
        setup(4, 32'h2000, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t5_fail_cleared", fail_check, 1'b0);

        // zero-length transfer
        setup(0, 32'h300, 1'b0);
        do_start(); wait_done(1'b0); end_checks();
        check("t6_latency", done_cyc - start_cyc, 1);
        check("t6_no_aw", aw_log.size(), 0);

        // ap_start while busy is ignored
        set_cfg(1, 1, 0, -1, 0, -1, -1, 2);
        setup(24, 32'h400, 1'b0);
        do_start(); wait_done(1'b1); end_checks();

        // reset during DATA, then a clean transfer
        set_cfg(1, 0, 0, -1, 0, -1, -1, 2);
        setup(30, 32'h500, 1'b0);
        do_start();
        for (int i = 0; i < 400 && !(w_idx >= 2 && M_WVALID); i++) @(negedge clk);
        check("t8_reached_data", M_WVALID, 1'b1);
        @(negedge clk);
        rstn = 0;
        #1;
        check_reset_vals("t8_async");
        repeat (2) @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);
        setup(10, 32'h600, 1'b0);
        do_start(); wait_done(1'b0); end_checks();

        // randomized transfers
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 70);
            set_cfg(1, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, n - 1),
                    $urandom_range(0, 6), $urandom_range(0, n - 1),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, (n - 1) / 16) : -1, 3);
            setup(n, ($urandom & 32'h000F_FFC0), 1'b0);
            do_start(); wait_done(1'b0); end_checks();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_dma_wr_engine.md
# axi_dma_wr_engine

AXI4 write-channel DMA master. On a start pulse it moves `num_trans` 32-bit words, pulled one at a time from a user-side producer, into memory starting at `mem_start_addr`, using INCR bursts of up to 16 beats. It sits between the accelerator's output buffer and the AXI interconnect or SRAM slave (`axi_sram_if`). It is the write counterpart of `axi_dma_rd`.

## Interface
- BITS_TRANS, 18: width of `num_trans`.
- OUT_BITS_TRANS, 13: width of the internal burst counter. `ceil(num_trans/16)` must fit in this width.
- AXI_WIDTH_USER, 1: width of the USER signals.
- AXI_WIDTH_ID, 4: width of the ID signals.
- AXI_WIDTH_AD, 32: address width.
- AXI_WIDTH_DA, 32: data width.
- AXI_WIDTH_DS, AXI_WIDTH_DA/8: strobe width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- M_AWVALID/M_AWREADY  out/in  1  address handshake.
- M_AWADDR  out  AD  burst start byte address.
- M_AWLEN  out  8  beats-1.
- M_AWID, M_WID  out  ID  constant 0.
- M_AWSIZE  out  3  constant log2(DS), which is 3'b010.
- M_AWBURST  out  2  constant 2'b01 (INCR).
- M_AWLOCK  out  2  constant 0.
- M_AWCACHE  out  4  constant 0.
- M_AWPROT  out  3  constant 0.
- M_AWQOS  out  4  constant 0.
- M_AWREGION  out  4  constant 0.
- M_AWUSER, M_WUSER  out  USER  constant 0.
- M_WVALID/M_WREADY  out/in  1  write-data handshake.
- M_WDATA  out  DA  beat data.
- M_WSTRB  out  DS  all ones.
- M_WLAST  out  1  final beat of a burst.
- M_BVALID/M_BREADY  in/out  1  response handshake.
- M_BRESP  in  2  write response.
- M_BID  in  ID  ignored.
- M_BUSER  in  USER  ignored.
- ap_start  in  1  single-cycle start pulse.
- ap_done  out  1  one-cycle completion pulse.
- num_trans  in  BITS_TRANS  word count; sampled at `ap_start`.
- mem_start_addr  in  AD  byte address; sampled at `ap_start`; 64-byte aligned.
- indata  in  DA  producer data.
- indata_req_o  out  1  one-cycle request for the next word.
- buff_valid  in  1  producer has data available; gates `indata_req_o`.
- fail_check  out  1  sticky error flag.

## Operation
- States are IDLE, ADDR, REQ, CAP, DATA, RESP and DONE.
- IDLE:
  - `ap_start`=1 latches `num_trans` into `remain` and `mem_start_addr` into `addr`, and clears `fail_check`.
  - Go to DONE if `num_trans`=0; otherwise go to ADDR.
  - `ap_start` is ignored in every other state.
- ADDR:
  - Set `blen = min(remain,16)`.
  - Drive `AWVALID`=1, `AWADDR=addr`, `AWLEN=blen-1`.
  - Hold these signals stable until `AWREADY`.
  - On handshake go to REQ with `beat`=0.
- REQ: wait for `buff_valid`=1, pulse `indata_req_o` for one cycle, then go to CAP.
- CAP: the producer drives `indata` during this cycle. Register it into `WDATA` at the ending edge, then go to DATA.
- DATA:
  - Drive `WVALID`=1 and `WLAST=(beat==blen-1)`.
  - Hold these signals and `WDATA` until `WREADY`.
  - On handshake: if this is the last beat, go to RESP; otherwise increment `beat` and go to REQ.
- RESP:
  - Drive `BREADY`=1 until `BVALID`.
  - If `BRESP`≠0, set `fail_check` (sticky until the next accepted `ap_start`).
  - Then `remain -= blen` and `addr += blen*DS`.
  - If `remain`>0, go to ADDR; otherwise go to DONE.
- DONE: drive `ap_done`=1 for exactly one cycle, then go to IDLE.
- The engine has one outstanding burst and one beat in flight. AW is never issued before the previous B response.
- Reset, including mid-burst, forces IDLE immediately. No B response is awaited after reset. All outputs return to reset values.

## Timing
- Reset values:
  - All VALID and READY outputs, `WLAST`, `ap_done`, `indata_req_o` and `fail_check` are 0.
  - `AWADDR`, `AWLEN` and `WDATA` are 0.
  - Constant outputs hold their constants.
- `ap_start` at edge t drives `AWVALID`=1 from cycle t+1.
- Per beat, with `WREADY` held high and `buff_valid`=1, the beat takes 3 cycles: `indata_req_o`, then capture, then the W handshake.
- `indata` must be valid in the cycle immediately after the `indata_req_o` cycle.
- `ap_done` is asserted in the cycle after the final B handshake.

## Test plan
- Single burst: bench with `axi_sram_if` + `sram`, `num_trans`=8, addr 0, producer returns 0..7.
  - Required: one AW with `AWLEN`=7, `AWADDR`=0.
  - `WLAST` only on beat 7; SRAM words 0..7 = 0..7.
  - One `ap_done` pulse; `fail_check`=0.
- Multi-burst: `num_trans`=40, addr 0x100.
  - Required: AWs (0x100, len 15), (0x140, len 15), (0x180, len 7).
  - 40 `indata_req_o` pulses; data lands in order.
- Backpressure: slave holds `WREADY` low 5 cycles on beat 3 and `AWREADY` low 4 cycles.
  - Required: `WDATA`, `WLAST`, `AWADDR` and `AWLEN` stay stable while stalled.
  - No extra `indata_req_o` pulses; the final memory contents are correct.
- Producer stall: `buff_valid`=0 for 10 cycles mid-burst.
  - Required: no `indata_req_o` while `buff_valid`=0; transfer resumes correctly.
- Error and edge cases:
  - `BRESP`=2'b10 on burst 1 of 2: `fail_check`=1 through `ap_done` and is cleared by the next `ap_start`.
  - `num_trans`=0: `ap_done` pulse with no AXI traffic.
- Reset mid-burst: deassert `rstn` during DATA.
  - Required: all outputs at reset values.
  - A new `ap_start` after release completes normally.
